// File: rtl/automat_racoritoare_pkg.sv
// Shared types and coin constants for the cola vending controller.
package automat_racoritoare_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam logic [3:0] C1     = 4'd1;
  localparam logic [3:0] C5     = 4'd5;
  localparam logic [3:0] C10    = 4'd10;
  localparam logic [3:0] R2_VAL = 4'd5;

  // Priority encode simultaneous coin events: 10 beats 5 beats 1.
  function automatic logic [3:0] coin_value(input logic e10, input logic e5, input logic e1);
    logic [3:0] v;
    v = 4'd0;
    if (e10)     v = C10;
    else if (e5) v = C5;
    else if (e1) v = C1;
    return v;
  endfunction

endpackage

// File: rtl/automat_racoritoare_coin_edge_detect.sv
// Rising-edge detector for one coin sensor; a held level counts once.
module coin_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= in;
  end

  assign rise = in & ~prev;

endmodule

// File: rtl/automat_racoritoare.sv
// Cola vending controller: accumulates coin credit, dispenses, then returns
// change one coin per cycle (5-unit coins first, then 1-unit coins).
//   state  | meaning
//   IDLE   | accepting coins, credit 0..PRICE-1
//   VEND   | cola pulse this cycle
//   CHANGE | returning change, one coin per cycle
module automat_racoritoare
  import automat_racoritoare_pkg::*;
#(
  parameter int PRICE = 3,
  parameter int CW    = 5
) (
  input  logic b1,
  input  logic b5,
  input  logic b10,
  input  logic clk,
  input  logic reset,
  output logic cola,
  output logic r1,
  output logic r2
);

  localparam logic [CW-1:0] PRICE_V = CW'(PRICE);
  localparam logic [CW-1:0] R2_V    = CW'(R2_VAL);
  localparam logic [CW-1:0] ONE_V   = CW'(1);

  state_t        state;
  logic [CW-1:0] credit;
  logic [CW-1:0] change;
  logic          e1, e5, e10;
  logic          coin_valid;
  logic [CW-1:0] coin_val;
  logic [CW-1:0] total;

  coin_edge_detect u_ed1  (.clk(clk), .reset(reset), .in(b1),  .rise(e1));
  coin_edge_detect u_ed5  (.clk(clk), .reset(reset), .in(b5),  .rise(e5));
  coin_edge_detect u_ed10 (.clk(clk), .reset(reset), .in(b10), .rise(e10));

  always_comb begin
    coin_valid = e1 | e5 | e10;
    coin_val   = CW'(coin_value(e10, e5, e1));
    total      = credit + coin_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      credit <= '0;
      change <= '0;
      cola   <= 1'b0;
      r1     <= 1'b0;
      r2     <= 1'b0;
    end else begin
      cola <= 1'b0;
      r1   <= 1'b0;
      r2   <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_valid) begin
            if (total >= PRICE_V) begin
              cola   <= 1'b1;
              change <= total - PRICE_V;
              credit <= '0;
              state  <= VEND;
            end else begin
              credit <= total;
            end
          end
        end
        VEND, CHANGE: begin
          // The first change pulse follows the cola pulse with no gap.
          if (change == '0) begin
            state <= IDLE;
          end else if (change >= R2_V) begin
            r2     <= 1'b1;
            change <= change - R2_V;
            state  <= (change == R2_V) ? IDLE : CHANGE;
          end else begin
            r1     <= 1'b1;
            change <= change - ONE_V;
            state  <= (change == ONE_V) ? IDLE : CHANGE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_automat_racoritoare.sv
// Bench for the cola vending controller: directed scenarios plus random coins
// compared cycle by cycle against a queue-based reference of expected pulses.
module tb_automat_racoritoare;

  localparam int PRICE = 3;
  localparam logic [2:0] O_NONE = 3'b000;
  localparam logic [2:0] O_COLA = 3'b100;
  localparam logic [2:0] O_R1   = 3'b010;
  localparam logic [2:0] O_R2   = 3'b001;

  logic clk = 1'b0;
  logic reset, b1, b5, b10;
  logic cola, r1, r2;

  int vectors = 0;
  int miscompares = 0;

  // reference state
  int         credit;
  logic       p1, p5, p10;
  logic [2:0] exp_out;
  logic [2:0] pending[$];

  automat_racoritoare #(.PRICE(PRICE), .CW(5)) dut (
    .b1(b1), .b5(b5), .b10(b10), .clk(clk), .reset(reset),
    .cola(cola), .r1(r1), .r2(r2)
  );

  always #5 clk = ~clk;

  // Expected outputs after the coming rising edge, given this cycle's inputs.
  task automatic model(input logic r, input logic i1, input logic i5, input logic i10);
    int v, t, ch;
    logic busy;
    if (r) begin
      credit = 0; p1 = 0; p5 = 0; p10 = 0;
      pending.delete();
      exp_out = O_NONE;
      return;
    end
    v = 0;
    if (i10 && !p10)     v = 10;
    else if (i5 && !p5)  v = 5;
    else if (i1 && !p1)  v = 1;
    p1 = i1; p5 = i5; p10 = i10;
    // machine is busy while cola is out or change coins are still owed
    busy = (exp_out == O_COLA) || (pending.size() != 0);
    if (!busy && v != 0) begin
      t = credit + v;
      if (t < PRICE) credit = t;
      else begin
        credit = 0;
        ch = t - PRICE;
        pending.push_back(O_COLA);
        for (int k = 0; k < ch / 5; k++) pending.push_back(O_R2);
        for (int k = 0; k < ch % 5; k++) pending.push_back(O_R1);
      end
    end
    if (pending.size() != 0) exp_out = pending.pop_front();
    else exp_out = O_NONE;
  endtask

  task automatic compare(input string tag, input logic [2:0] want);
    vectors++;
    assert ({cola, r1, r2} === want)
    else begin
      miscompares++;
      $error("FAIL %s: got cola/r1/r2=%b expected %b", tag, {cola, r1, r2}, want);
    end
  endtask

  task automatic cyc(input logic r, input logic i1, input logic i5, input logic i10);
    reset = r; b1 = i1; b5 = i5; b10 = i10;
    model(r, i1, i5, i10);
    @(posedge clk);
    #1;
    compare("model", exp_out);
  endtask

  initial begin
    logic l1, l5, l10, lr;
    credit = 0; p1 = 0; p5 = 0; p10 = 0; exp_out = O_NONE;

    // reset, then 10-unit coin: change 7 = 5 + 1 + 1
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); compare("reset", O_NONE);
    cyc(0, 0, 0, 1); compare("b10_cola", O_COLA);
    cyc(0, 0, 0, 0); compare("b10_r2", O_R2);
    cyc(0, 0, 0, 0); compare("b10_r1a", O_R1);
    cyc(0, 0, 0, 0); compare("b10_r1b", O_R1);
    cyc(0, 0, 0, 0); compare("b10_idle", O_NONE);

    // 5-unit coin: change 2
    cyc(0, 0, 1, 0); compare("b5_cola", O_COLA);
    cyc(0, 0, 0, 0); compare("b5_r1a", O_R1);
    cyc(0, 0, 0, 0); compare("b5_r1b", O_R1);
    cyc(0, 0, 0, 0); compare("b5_idle", O_NONE);

    // three 1-unit coins: exact price, no change
    cyc(0, 1, 0, 0); compare("b1_first", O_NONE);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); compare("b1_second", O_NONE);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); compare("b1_third_cola", O_COLA);
    cyc(0, 0, 0, 0); compare("b1_no_change", O_NONE);
    cyc(0, 0, 0, 0);

    // held 1-unit sensor counts once
    for (int k = 0; k < 4; k++) begin cyc(0, 1, 0, 0); compare("b1_held", O_NONE); end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); compare("b1_held_plus1", O_NONE);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); compare("b1_held_plus2_cola", O_COLA);
    cyc(0, 0, 0, 0);

    // simultaneous 10 and 1: only 10 counts
    cyc(0, 1, 0, 1); compare("b10b1_cola", O_COLA);
    cyc(0, 0, 0, 0); compare("b10b1_r2", O_R2);
    cyc(0, 0, 0, 0); compare("b10b1_r1a", O_R1);
    cyc(0, 0, 0, 0); compare("b10b1_r1b", O_R1);
    cyc(0, 0, 0, 0); compare("b10b1_idle", O_NONE);
    cyc(0, 0, 0, 0); compare("b10b1_nocredit", O_NONE);

    // coin during vend/change is rejected and not credited
    cyc(0, 0, 1, 0); compare("busy_cola", O_COLA);
    cyc(0, 1, 0, 0); compare("busy_r1a", O_R1);
    cyc(0, 0, 0, 0); compare("busy_r1b", O_R1);
    cyc(0, 1, 0, 0); compare("busy_after1", O_NONE);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0); compare("busy_after2", O_NONE);
    cyc(0, 0, 0, 0);

    // reset abandons pending change
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1); compare("rst_cola", O_COLA);
    cyc(0, 0, 0, 0); compare("rst_r2", O_R2);
    cyc(1, 0, 0, 0); compare("rst_abort", O_NONE);
    cyc(0, 0, 0, 0); compare("rst_quiet1", O_NONE);
    cyc(0, 0, 0, 0); compare("rst_quiet2", O_NONE);
    cyc(0, 0, 1, 0); compare("rst_b5_cola", O_COLA);
    cyc(0, 0, 0, 0); compare("rst_b5_r1a", O_R1);
    cyc(0, 0, 0, 0); compare("rst_b5_r1b", O_R1);
    cyc(0, 0, 0, 0); compare("rst_b5_idle", O_NONE);

    // random sensor levels with persistence and occasional reset
    l1 = 0; l5 = 0; l10 = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) l1 = ~l1;
      if ($urandom_range(0, 7) == 0) l5 = ~l5;
      if ($urandom_range(0, 9) == 0) l10 = ~l10;
      lr = ($urandom_range(0, 99) == 0);
      cyc(lr, l1, l5, l10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
